// File: rtl/mac_accumulator.sv
// Signed Q8.8 multiply-accumulate stage feeding the ReLU stage: dot product over LEN pairs,
// two-stage pipeline (product register, accumulator), round-half-up and saturate to 16 bits.
module mac_accumulator #(
   parameter int LEN_W = 8,
   parameter int ACC_W = 40
) (
   input  logic             CLK,
   input  logic             RST_MAC,
   input  logic             START,
   input  logic [LEN_W-1:0] LEN,
   input  logic             IN_VALID,
   input  logic [15:0]      A_IN,
   input  logic [15:0]      B_IN,
   output logic             BUSY,
   output logic [15:0]      Data_Reg,
   output logic             En_MAC_ReLU,
   output logic             SAT_FLAG
);

   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_t;

   localparam logic signed [ACC_W-1:0] Q_MAX = {{(ACC_W-16){1'b0}}, 16'h7FFF};
   localparam logic signed [ACC_W-1:0] Q_MIN = {{(ACC_W-16){1'b1}}, 16'h8000};
   localparam logic signed [ACC_W-1:0] ROUND = {{(ACC_W-8){1'b0}}, 8'h80};

   state_t                  state, state_nxt;
   logic [LEN_W-1:0]        len_q, cnt;
   logic signed [31:0]      a_ext, b_ext, prod;
   logic                    prod_vld;
   logic signed [ACC_W-1:0] acc, rnd_sum, rnd;
   logic                    accept, start_ok, last;

   assign a_ext   = {{16{A_IN[15]}}, A_IN};
   assign b_ext   = {{16{B_IN[15]}}, B_IN};
   assign last    = (cnt + LEN_W'(1)) == len_q;
   assign rnd_sum = acc + ROUND;
   assign rnd     = rnd_sum >>> 8;
   assign BUSY    = (state != IDLE);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK or posedge RST_MAC) begin
      if (RST_MAC) state <= IDLE;
      else         state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      start_ok  = 1'b0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (START) begin
               start_ok  = 1'b1;
               state_nxt = (LEN == '0) ? OUT : ACCUM;
            end
         end
         ACCUM: begin
            if (IN_VALID) begin
               accept = 1'b1;
               if (last) state_nxt = DRAIN;
            end
         end
         DRAIN:   state_nxt = OUT;
         OUT:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST_MAC) begin
      if (RST_MAC) begin
         len_q       <= '0;
         cnt         <= '0;
         prod        <= '0;
         prod_vld    <= 1'b0;
         acc         <= '0;
         Data_Reg    <= '0;
         SAT_FLAG    <= 1'b0;
         En_MAC_ReLU <= 1'b0;
      end else begin
         En_MAC_ReLU <= 1'b0;
         prod_vld    <= accept;
         if (accept) begin
            prod <= a_ext * b_ext;
            cnt  <= cnt + LEN_W'(1);
         end
         if (start_ok) begin
            acc   <= '0;
            len_q <= LEN;
            cnt   <= '0;
         end else if (prod_vld) begin
            acc <= acc + {{(ACC_W-32){prod[31]}}, prod};
         end
         // The accumulator is final by the time OUT is reached; convert on its exit edge.
         if (state == OUT) begin
            En_MAC_ReLU <= 1'b1;
            if (rnd > Q_MAX) begin
               Data_Reg <= 16'h7FFF;
               SAT_FLAG <= 1'b1;
            end else if (rnd < Q_MIN) begin
               Data_Reg <= 16'h8000;
               SAT_FLAG <= 1'b1;
            end else begin
               Data_Reg <= rnd[15:0];
               SAT_FLAG <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_mac_accumulator.sv
// Scoreboard bench for mac_accumulator: expected {SAT_FLAG, Data_Reg} is pushed when a run is
// driven and popped when the strobe appears; each test task does its own inline comparisons.
module tb_mac_accumulator;

   logic        CLK = 1'b0;
   logic        RST_MAC = 1'b0;
   logic        START = 1'b0;
   logic [7:0]  LEN = '0;
   logic        IN_VALID = 1'b0;
   logic [15:0] A_IN = '0;
   logic [15:0] B_IN = '0;
   logic        BUSY;
   logic [15:0] Data_Reg;
   logic        En_MAC_ReLU;
   logic        SAT_FLAG;

   int n_cmp = 0;
   int n_bad = 0;

   logic [15:0] pa [8];
   logic [15:0] pb [8];
   logic [16:0] sb [$];

   mac_accumulator #(.LEN_W(8), .ACC_W(40)) dut (
      .CLK(CLK), .RST_MAC(RST_MAC), .START(START), .LEN(LEN), .IN_VALID(IN_VALID),
      .A_IN(A_IN), .B_IN(B_IN), .BUSY(BUSY), .Data_Reg(Data_Reg),
      .En_MAC_ReLU(En_MAC_ReLU), .SAT_FLAG(SAT_FLAG)
   );

   initial forever #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: exact sum of products, round half up, saturate to Q8.8.
   function automatic logic [16:0] model(input int n);
      longint s = 0;
      for (int i = 0; i < n; i++)
         s += longint'($signed(pa[i])) * longint'($signed(pb[i]));
      s = (s + 128) >>> 8;
      if (s > 32767)  return {1'b1, 16'h7FFF};
      if (s < -32768) return {1'b1, 16'h8000};
      return {1'b0, s[15:0]};
   endfunction

   // Called #1 after a posedge; returns #1 after the START-accept edge.
   task automatic start_run(input int len);
      START = 1'b1;
      LEN   = len[7:0];
      @(posedge CLK); #1;
      START = 1'b0;
   endtask

   // Drives n pairs with gap idle cycles between; returns #1 after the last accept edge.
   task automatic feed(input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         IN_VALID = 1'b1;
         A_IN     = pa[i];
         B_IN     = pb[i];
         @(posedge CLK); #1;
         IN_VALID = 1'b0;
         A_IN     = 16'h5A5A;
         B_IN     = 16'hA5A5;
         if (i != n - 1) repeat (gap) begin @(posedge CLK); #1; end
      end
   endtask

   // Waits (bounded) for the strobe and pops the scoreboard; no comparisons here.
   task automatic collect(output int lat, output logic seen, output logic busy_at,
                          output logic [16:0] got, output logic [16:0] exp);
      lat  = 0;
      seen = 1'b0;
      while (lat < 20 && !seen) begin
         @(posedge CLK); #1;
         lat++;
         if (En_MAC_ReLU) seen = 1'b1;
      end
      busy_at = BUSY;
      got     = {SAT_FLAG, Data_Reg};
      exp     = (sb.size() != 0) ? sb.pop_front() : 17'h1FFFF;
   endtask

   task automatic test_reset();
      int strobes = 0;
      int busies  = 0;
      #2 RST_MAC = 1'b1;
      #1;
      n_cmp++;
      if ({BUSY, Data_Reg, En_MAC_ReLU, SAT_FLAG} !== 19'h0) begin
         n_bad++;
         $display("FAIL reset_async: busy=%b data=%h en=%b sat=%b, need all 0",
                  BUSY, Data_Reg, En_MAC_ReLU, SAT_FLAG);
      end
      repeat (2) @(posedge CLK);
      @(negedge CLK) RST_MAC = 1'b0;
      repeat (10) begin
         @(posedge CLK); #1;
         if (En_MAC_ReLU) strobes++;
         if (BUSY) busies++;
      end
      n_cmp++;
      if (strobes != 0 || busies != 0) begin
         n_bad++;
         $display("FAIL reset_idle: strobes=%0d busy_cycles=%0d, need 0/0", strobes, busies);
      end
   endtask

   task automatic test_single();
      int lat; logic seen, busy_at; logic [16:0] got, exp;
      pa[0] = 16'h0100; pb[0] = 16'h0200;
      sb.push_back(model(1));
      start_run(1);
      n_cmp++;
      if (BUSY !== 1'b1) begin n_bad++; $display("FAIL single_busy_rise: busy=%b need 1", BUSY); end
      feed(1, 0);
      collect(lat, seen, busy_at, got, exp);
      n_cmp++;
      if (!seen) begin n_bad++; $display("FAIL single_timeout: no strobe within 20 cycles"); end
      else begin
         n_cmp += 3;
         if (got !== exp) begin n_bad++; $display("FAIL single_data: got %h need %h", got, exp); end
         if (lat != 2) begin n_bad++; $display("FAIL single_latency: %0d edges need 2", lat); end
         if (busy_at !== 1'b0) begin n_bad++; $display("FAIL single_busy_fall: busy=%b need 0", busy_at); end
      end
      @(posedge CLK); #1;
      n_cmp++;
      if (En_MAC_ReLU !== 1'b0) begin n_bad++; $display("FAIL single_strobe_width: en=%b need 0", En_MAC_ReLU); end
      n_cmp++;
      if (Data_Reg !== 16'h0200) begin n_bad++; $display("FAIL single_hold: data=%h need 0200", Data_Reg); end
   endtask

   task automatic test_multi_gaps();
      int lat; logic seen, busy_at; logic [16:0] got, exp;
      pa[0] = 16'h0180; pb[0] = 16'h0200;
      pa[1] = 16'hFF00; pb[1] = 16'h0080;
      pa[2] = 16'h0040; pb[2] = 16'h0040;
      // Valid data while IDLE (and on the START edge) must be ignored.
      IN_VALID = 1'b1; A_IN = 16'h7FFF; B_IN = 16'h7FFF;
      repeat (3) begin @(posedge CLK); #1; end
      sb.push_back(model(3));
      start_run(3);
      feed(3, 2);
      collect(lat, seen, busy_at, got, exp);
      n_cmp++;
      if (!seen) begin n_bad++; $display("FAIL multi_timeout: no strobe"); end
      else begin
         n_cmp += 2;
         if (got !== exp) begin n_bad++; $display("FAIL multi_data: got %h need %h", got, exp); end
         if (lat != 2) begin n_bad++; $display("FAIL multi_latency: %0d edges need 2", lat); end
      end
   endtask

   task automatic test_saturation();
      int lat; logic seen, busy_at; logic [16:0] got, exp;
      for (int i = 0; i < 4; i++) begin pa[i] = 16'h7FFF; pb[i] = 16'h7FFF; end
      sb.push_back(model(4));
      start_run(4);
      feed(4, 0);
      collect(lat, seen, busy_at, got, exp);
      n_cmp++;
      if (!seen || got !== exp) begin n_bad++; $display("FAIL sat_pos: seen=%b got %h need %h", seen, got, exp); end
      pa[0] = 16'h8000; pb[0] = 16'h7FFF;
      sb.push_back(model(1));
      start_run(1);
      feed(1, 0);
      collect(lat, seen, busy_at, got, exp);
      n_cmp++;
      if (!seen || got !== exp) begin n_bad++; $display("FAIL sat_neg: seen=%b got %h need %h", seen, got, exp); end
   endtask

   task automatic test_rounding();
      int lat; logic seen, busy_at; logic [16:0] got, exp;
      logic [15:0] ta [3];
      logic [15:0] tb [3];
      ta = '{16'h0001, 16'hFFFF, 16'hFFFF};
      tb = '{16'h0080, 16'h0080, 16'h0081};
      for (int k = 0; k < 3; k++) begin
         pa[0] = ta[k]; pb[0] = tb[k];
         sb.push_back(model(1));
         start_run(1);
         feed(1, 0);
         collect(lat, seen, busy_at, got, exp);
         n_cmp++;
         if (!seen || got !== exp)
            begin n_bad++; $display("FAIL round_%0d: seen=%b got %h need %h", k, seen, got, exp); end
      end
   endtask

   task automatic test_len_zero();
      int lat; logic seen, busy_at; logic [16:0] got, exp;
      sb.push_back(model(0));
      start_run(0);
      collect(lat, seen, busy_at, got, exp);
      n_cmp++;
      if (!seen) begin n_bad++; $display("FAIL len0_timeout: no strobe"); end
      else begin
         n_cmp += 2;
         if (got !== exp) begin n_bad++; $display("FAIL len0_data: got %h need %h", got, exp); end
         if (lat != 1) begin n_bad++; $display("FAIL len0_latency: %0d edges need 1", lat); end
      end
   endtask

   task automatic test_start_busy();
      int lat; logic seen, busy_at; logic [16:0] got, exp;
      int extra = 0;
      pa[0] = 16'h0100; pb[0] = 16'h0300;
      pa[1] = 16'h0200; pb[1] = 16'h0100;
      sb.push_back(model(2));
      start_run(2);
      // START re-asserted and LEN changed while BUSY: both must be ignored.
      START = 1'b1; LEN = 8'd1;
      feed(2, 1);
      START = 1'b0;
      collect(lat, seen, busy_at, got, exp);
      n_cmp++;
      if (!seen || got !== exp || lat != 2)
         begin n_bad++; $display("FAIL busy_start: seen=%b lat=%0d got %h need %h", seen, lat, got, exp); end
      repeat (5) begin
         @(posedge CLK); #1;
         if (En_MAC_ReLU || BUSY) extra++;
      end
      n_cmp++;
      if (extra != 0) begin n_bad++; $display("FAIL busy_start_extra: %0d active cycles need 0", extra); end
   endtask

   task automatic test_back_to_back();
      int lat; logic seen, busy_at; logic [16:0] got, exp;
      pa[0] = 16'h0200; pb[0] = 16'h0200;
      sb.push_back(model(1));
      start_run(1);
      feed(1, 0);
      collect(lat, seen, busy_at, got, exp);
      n_cmp++;
      if (!seen || got !== exp) begin n_bad++; $display("FAIL b2b_first: seen=%b got %h need %h", seen, got, exp); end
      // START in the strobe cycle.
      pa[0] = 16'h0400; pb[0] = 16'h0080;
      sb.push_back(model(1));
      start_run(1);
      n_cmp++;
      if (BUSY !== 1'b1) begin n_bad++; $display("FAIL b2b_accept: busy=%b need 1", BUSY); end
      feed(1, 0);
      collect(lat, seen, busy_at, got, exp);
      n_cmp++;
      if (!seen || got !== exp || lat != 2)
         begin n_bad++; $display("FAIL b2b_second: seen=%b lat=%0d got %h need %h", seen, lat, got, exp); end
   endtask

   task automatic test_abort();
      int lat; logic seen, busy_at; logic [16:0] got, exp;
      int strobes = 0;
      int busies  = 0;
      for (int i = 0; i < 4; i++) begin pa[i] = 16'h0100; pb[i] = 16'h0100; end
      start_run(4);
      feed(2, 0);
      #2 RST_MAC = 1'b1;
      #1;
      n_cmp++;
      if ({BUSY, Data_Reg, En_MAC_ReLU, SAT_FLAG} !== 19'h0) begin
         n_bad++;
         $display("FAIL abort_outputs: busy=%b data=%h en=%b sat=%b, need all 0",
                  BUSY, Data_Reg, En_MAC_ReLU, SAT_FLAG);
      end
      @(negedge CLK) RST_MAC = 1'b0;
      repeat (8) begin
         @(posedge CLK); #1;
         if (En_MAC_ReLU) strobes++;
         if (BUSY) busies++;
      end
      n_cmp++;
      if (strobes != 0 || busies != 0)
         begin n_bad++; $display("FAIL abort_quiet: strobes=%0d busy_cycles=%0d need 0/0", strobes, busies); end
      pa[0] = 16'h0300; pb[0] = 16'h0100;
      sb.push_back(model(1));
      start_run(1);
      feed(1, 0);
      collect(lat, seen, busy_at, got, exp);
      n_cmp++;
      if (!seen || got !== exp || lat != 2)
         begin n_bad++; $display("FAIL abort_rerun: seen=%b lat=%0d got %h need %h", seen, lat, got, exp); end
   endtask

   initial begin
      test_reset();
      @(posedge CLK); #1;
      test_single();
      test_multi_gaps();
      test_saturation();
      test_rounding();
      test_len_zero();
      test_start_busy();
      test_back_to_back();
      test_abort();
      n_cmp++;
      if (sb.size() != 0) begin n_bad++; $display("FAIL scoreboard_leftover: %0d entries need 0", sb.size()); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mac_accumulator.md
# mac_accumulator

Multiply-accumulate stage that directly feeds the ReLU stage. It computes a signed Q8.8 dot product over a run-time number of operand pairs and rounds and saturates the result to 16 bits. It presents the result on `Data_Reg` with a one-cycle `En_MAC_ReLU` strobe, which the ReLU stage samples as its data and enable inputs. Operation uses a two-stage pipeline (multiply register, then accumulate) under a four-state control FSM.

## Interface

Parameters:
- `LEN_W`, default 8: width of the product-count input; up to 2^LEN_W − 1 products per run.
- `ACC_W`, default 40: accumulator width. Must be ≥ 32 + `LEN_W`, so the accumulator can never wrap.

Ports:
- `CLK` in 1: single clock. All state changes on the rising edge.
- `RST_MAC` in 1: reset, asynchronous, active-high.
- `START` in 1: begin a run. Sampled only in IDLE.
- `LEN` in `LEN_W`: number of products in the run. Latched when `START` is accepted.
- `IN_VALID` in 1: the operand pair on `A_IN`/`B_IN` is valid this cycle.
- `A_IN` in 16: signed Q8.8 operand.
- `B_IN` in 16: signed Q8.8 operand.
- `BUSY` out 1: high in every state except IDLE.
- `Data_Reg` out 16: signed Q8.8 result. Holds its value until the next result.
- `En_MAC_ReLU` out 1: one-cycle strobe marking a new `Data_Reg`.
- `SAT_FLAG` out 1: the current `Data_Reg` was saturated. Updated together with `Data_Reg`.

## Operation

FSM states and transitions:
- IDLE → ACCUM when `START`=1 and `LEN`≠0. On entry: accumulator cleared, `LEN` latched, count cleared.
- IDLE → OUT when `START`=1 and `LEN`=0. The result is 0.
- ACCUM: each cycle with `IN_VALID`=1 accepts one pair and increments count. The pair that brings count to `LEN` moves the FSM to DRAIN.
- DRAIN: one cycle, then → OUT.
- OUT: one cycle, then → IDLE.

Pipeline:
- Stage 1: a pair accepted at edge e loads the 32-bit signed product A×B (Q16.16) into the product register, and sets a product-valid bit.
- Stage 2: at edge e+1, if product-valid is set, the product is sign-extended to `ACC_W` and added to the accumulator.

Output conversion, in OUT, registered at the exit edge:
- r = (acc + 0x80) >>> 8, i.e. arithmetic shift with round-half-up.
- r > 32767 → `Data_Reg`=0x7FFF, `SAT_FLAG`=1.
- r < −32768 → `Data_Reg`=0x8000, `SAT_FLAG`=1.
- Otherwise `Data_Reg`=r[15:0], `SAT_FLAG`=0.

Boundary conditions:
- `IN_VALID` outside ACCUM is ignored.
- `START` while `BUSY`=1 is ignored.
- A gap in `IN_VALID` during ACCUM stalls the count only. There is no timeout.
- `LEN`/`A_IN`/`B_IN` changes during a run do not affect the latched `LEN`.
- `START` in the same cycle that `En_MAC_ReLU` is high is accepted, because the FSM is already in IDLE.
- `RST_MAC` mid-run aborts the run immediately. No strobe is issued, and all outputs return to their reset values.

## Timing

- Reset values: state IDLE, accumulator 0, product register 0, product-valid 0, count 0, `BUSY`=0, `Data_Reg`=0x0000, `En_MAC_ReLU`=0, `SAT_FLAG`=0.
- `BUSY` rises in the cycle after the edge that accepts `START`.
- Latency: last pair accepted at edge e → accumulator final at e+1 → `Data_Reg`, `SAT_FLAG` and `En_MAC_ReLU` registered at e+2. The strobe is high for exactly the cycle after e+2.
- `BUSY` falls at e+2, in the same cycle the strobe is high.
- `LEN`=0: `START` accepted at edge s → strobe registered at s+1, `Data_Reg`=0x0000, `SAT_FLAG`=0.
- Minimum run period: `LEN`+3 cycles (`START`, `LEN` accepts, DRAIN, OUT).
- Throughput: one pair per cycle in ACCUM.

## Test plan

- Reset: assert `RST_MAC` asynchronously with no clock edge -> all outputs 0 immediately. Deassert; `START`=0 for 10 cycles -> `BUSY`=0 and no strobe.
- Single product: `LEN`=1, `A_IN`=0x0100, `B_IN`=0x0200 -> `Data_Reg`=0x0200, `SAT_FLAG`=0, strobe exactly 2 edges after the accept edge, one cycle wide.
- Multi-product with `IN_VALID` gaps: `LEN`=3, pairs (0x0180,0x0200), (0xFF00,0x0080), (0x0040,0x0040) with idle cycles between them -> `Data_Reg`=0x0290.
- Saturation:
  - `LEN`=4, all pairs (0x7FFF,0x7FFF) -> `Data_Reg`=0x7FFF, `SAT_FLAG`=1.
  - `LEN`=1, (0x8000,0x7FFF) -> `Data_Reg`=0x8000, `SAT_FLAG`=1.
- Rounding:
  - (0x0001,0x0080) -> 0x0001.
  - (0xFFFF,0x0080) -> 0x0000.
  - (0xFFFF,0x0081) -> 0xFFFF.
- Control corners:
  - `LEN`=0 -> strobe 1 edge after `START`, `Data_Reg`=0x0000.
  - `START` pulsed while `BUSY`=1 -> ignored.
  - `RST_MAC` after 2 of 4 pairs -> no strobe, `BUSY`=0; the next `LEN`=1 run gives its correct result.
